// File: rtl/status_interrupt_unit.sv
// Processor status register P with flag commit, IRQ/NMI synchronisation and the interrupt request handshake.
// Optional WAI stall support is compiled in when STATUS_WAI_EN is defined.
module status_interrupt_unit #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_P     = 8'h34,
  parameter logic [15:0] NMI_VECTOR  = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR  = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  flags_out,
  input  logic [7:0]  flags_ena,
  input  logic        flags_wr,
  input  logic        p_load,
  input  logic [7:0]  p_load_data,
  input  logic        push_b,
  input  logic        instr_done,
  input  logic        int_ack,
  input  logic        irq_n,
  input  logic        nmi_n,
  input  logic        wai_req,
  output logic [7:0]  flags_in,
  output logic [7:0]  p_push,
  output logic        int_req,
  output logic        int_is_nmi,
  output logic [15:0] int_vector,
  output logic        wai_halt
);

`ifdef STATUS_WAI_EN
  typedef enum logic [1:0] {IDLE, REQ, SVC, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
`endif

  state_t state_q, state_nxt;

  logic [7:0]             p_q, p_nxt;
  logic [SYNC_STAGES-1:0] irq_sync, nmi_sync;
  logic                   irq_s, nmi_s, nmi_s_d;
  logic                   nmi_fall, nmi_latch_q;
  logic                   i_eff_q, irq_pend;
  logic                   int_is_nmi_q, nmi_sel_nxt;
  logic                   ack_req;

`ifndef STATUS_WAI_EN
  logic unused_wai_req;
  assign unused_wai_req = wai_req;
`endif

  assign irq_s    = irq_sync[SYNC_STAGES-1];
  assign nmi_s    = nmi_sync[SYNC_STAGES-1];
  assign nmi_fall = nmi_s_d & ~nmi_s;
  assign irq_pend = ~irq_s & ~i_eff_q;
  assign ack_req  = (state_q == REQ) & int_ack;

  // Bits 5 and 4 are held at 1 so the register reads back exactly as flags_in.
  always_comb begin
    p_nxt = p_q;
    if (flags_wr) p_nxt = (p_q & ~flags_ena) | (flags_out & flags_ena);
    if (p_load)   p_nxt = p_load_data;
    if (ack_req)  p_nxt[2] = 1'b1;
    p_nxt[5:4] = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q          <= RESET_P | 8'h30;
      irq_sync     <= '1;
      nmi_sync     <= '1;
      nmi_s_d      <= 1'b1;
      nmi_latch_q  <= 1'b0;
      i_eff_q      <= 1'b1;
      int_is_nmi_q <= 1'b0;
    end else begin
      p_q          <= p_nxt;
      irq_sync     <= {irq_sync[SYNC_STAGES-2:0], irq_n};
      nmi_sync     <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
      nmi_s_d      <= nmi_s;
      // A fresh edge coinciding with the NMI acknowledge keeps the latch set.
      nmi_latch_q  <= nmi_fall | (nmi_latch_q & ~(ack_req & int_is_nmi_q));
      if (instr_done) i_eff_q <= p_q[2];
      int_is_nmi_q <= nmi_sel_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    nmi_sel_nxt = int_is_nmi_q;
    case (state_q)
      IDLE: begin
        if (instr_done && (nmi_latch_q || irq_pend)) begin
          state_nxt   = REQ;
          nmi_sel_nxt = nmi_latch_q;
        end
`ifdef STATUS_WAI_EN
        else if (wai_req) begin
          state_nxt = WAIT;
        end
`endif
      end
      REQ: begin
        if (int_ack) state_nxt = SVC;
      end
      SVC: begin
        if (instr_done) state_nxt = IDLE;
      end
`ifdef STATUS_WAI_EN
      // Any asserted interrupt line wakes the core; only unmasked ones vector.
      WAIT: begin
        if (nmi_latch_q || !irq_s) begin
          if (nmi_latch_q || irq_pend) begin
            state_nxt   = REQ;
            nmi_sel_nxt = nmi_latch_q;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign flags_in   = p_q;
  assign p_push     = {p_q[7:6], 1'b1, push_b, p_q[3:0]};
  assign int_req    = (state_q == REQ);
  assign int_is_nmi = int_is_nmi_q;
  assign int_vector = int_is_nmi_q ? NMI_VECTOR : IRQ_VECTOR;
`ifdef STATUS_WAI_EN
  assign wai_halt   = (state_q == WAIT);
`else
  assign wai_halt   = 1'b0;
`endif

endmodule

// File: tb/tb_status_interrupt_unit.sv
// Directed bench for status_interrupt_unit with a cycle-level reference model of P and the interrupt handshake.
module tb_status_interrupt_unit;
  localparam int S = 2;
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2, M_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  flags_out = 8'h00, flags_ena = 8'h00, p_load_data = 8'h00;
  logic        flags_wr = 1'b0, p_load = 1'b0, push_b = 1'b1, instr_done = 1'b0;
  logic        int_ack = 1'b0, irq_n = 1'b1, nmi_n = 1'b1, wai_req = 1'b0;
  logic [7:0]  flags_in, p_push;
  logic        int_req, int_is_nmi, wai_halt;
  logic [15:0] int_vector;

  int n_tests = 0;
  int n_fail  = 0;

  status_interrupt_unit #(.SYNC_STAGES(S), .RESET_P(8'h34),
                          .NMI_VECTOR(16'hFFFA), .IRQ_VECTOR(16'hFFFE)) dut (
    .clk(clk), .rst_n(rst_n), .flags_out(flags_out), .flags_ena(flags_ena),
    .flags_wr(flags_wr), .p_load(p_load), .p_load_data(p_load_data), .push_b(push_b),
    .instr_done(instr_done), .int_ack(int_ack), .irq_n(irq_n), .nmi_n(nmi_n),
    .wai_req(wai_req), .flags_in(flags_in), .p_push(p_push), .int_req(int_req),
    .int_is_nmi(int_is_nmi), .int_vector(int_vector), .wai_halt(wai_halt)
  );

  always #5 clk = ~clk;

  // Reference model: pin samples kept as history arrays, interrupt flow as a mode number.
  logic [7:0] m_p;
  logic       iq [0:S-1];
  logic       nq [0:S];
  logic       m_latch, m_ieff, m_isnmi;
  int         m_mode;
  logic       b_irq_s, b_nmi_s, b_nmi_prev, b_pend, b_ack, b_wake;
  logic [7:0] b_p;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_p = 8'h34; m_latch = 1'b0; m_ieff = 1'b1; m_isnmi = 1'b0; m_mode = M_IDLE;
      for (int i = 0; i < S; i++) iq[i] = 1'b1;
      for (int i = 0; i <= S; i++) nq[i] = 1'b1;
    end else begin
      b_irq_s    = iq[S-1];
      b_nmi_s    = nq[S-1];
      b_nmi_prev = nq[S];
      b_pend     = !b_irq_s && !m_ieff;
      b_ack      = (m_mode == M_REQ) && int_ack;
      b_p = m_p;
      for (int i = 0; i < 8; i++) if (flags_wr && flags_ena[i]) b_p[i] = flags_out[i];
      if (p_load) b_p = p_load_data;
      if (b_ack) b_p[2] = 1'b1;
      b_p[5] = 1'b1; b_p[4] = 1'b1;
      if (instr_done) m_ieff = m_p[2];
      b_wake = 1'b0;
      if (m_mode == M_IDLE) begin
        if (instr_done && (m_latch || b_pend)) begin m_mode = M_REQ; m_isnmi = m_latch; end
`ifdef STATUS_WAI_EN
        else if (wai_req) m_mode = M_WAIT;
`endif
      end else if (m_mode == M_REQ) begin
        if (int_ack) m_mode = M_SVC;
      end else if (m_mode == M_SVC) begin
        if (instr_done) m_mode = M_IDLE;
      end else begin
        b_wake = m_latch || !b_irq_s;
        if (b_wake && (m_latch || b_pend)) begin m_mode = M_REQ; m_isnmi = m_latch; end
        else if (b_wake) m_mode = M_IDLE;
      end
      if (b_ack && m_isnmi && !(b_nmi_prev && !b_nmi_s)) m_latch = 1'b0;
      if (b_nmi_prev && !b_nmi_s) m_latch = 1'b1;
      m_p = b_p;
      for (int i = S-1; i > 0; i--) iq[i] = iq[i-1];
      iq[0] = irq_n;
      for (int i = S; i > 0; i--) nq[i] = nq[i-1];
      nq[0] = nmi_n;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("flags_in",   {8'h00, flags_in}, {8'h00, m_p});
    check("p_push",     {8'h00, p_push},   {8'h00, m_p[7:6], 1'b1, push_b, m_p[3:0]});
    check("int_req",    {15'd0, int_req},  {15'd0, m_mode == M_REQ});
    check("int_is_nmi", {15'd0, int_is_nmi}, {15'd0, m_isnmi});
    check("int_vector", int_vector, m_isnmi ? 16'hFFFA : 16'hFFFE);
    check("wai_halt",   {15'd0, wai_halt}, {15'd0, m_mode == M_WAIT});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_done();
    instr_done = 1'b1; tick(); instr_done = 1'b0;
  endtask

  task automatic set_i(input logic v);
    flags_wr = 1'b1; flags_ena = 8'h04; flags_out = {5'd0, v, 2'd0};
    tick();
    flags_wr = 1'b0; flags_ena = 8'h00; flags_out = 8'h00;
  endtask

  task automatic check_reset_lits();
    check("rst_flags_in", {8'h00, flags_in}, 16'h0034);
    check("rst_int_req",  {15'd0, int_req}, 16'd0);
    check("rst_is_nmi",   {15'd0, int_is_nmi}, 16'd0);
    check("rst_vector",   int_vector, 16'hFFFE);
    check("rst_wai_halt", {15'd0, wai_halt}, 16'd0);
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1 check_reset_lits();
    ticks(2);
    rst_n = 1'b1;
    tick();

    // Flag commit and PLP priority
    flags_wr = 1'b1; flags_out = 8'hC3; flags_ena = 8'hC3;
    tick();
    check("commit_C3", {8'h00, flags_in}, 16'h00F7);
    flags_ena = 8'h01; flags_out = 8'h00; p_load = 1'b1; p_load_data = 8'h01; push_b = 1'b0;
    tick();
    check("plp_wins", {8'h00, flags_in}, 16'h0031);
    check("push_hw",  {8'h00, p_push},   16'h0021);
    flags_wr = 1'b0; flags_ena = 8'h00; p_load = 1'b0; push_b = 1'b1;
    set_i(1'b1);

    // Delayed I-mask: CLI before instr_done #1, request only at #2
    irq_n = 1'b0;
    ticks(4);
    check("masked_irq", {15'd0, int_req}, 16'd0);
    set_i(1'b0);
    pulse_done();
    check("cli_done1", {15'd0, int_req}, 16'd0);
    ticks(2);
    pulse_done();
    check("cli_done2", {15'd0, int_req}, 16'd1);
    check("irq_vec",   int_vector, 16'hFFFE);
    irq_n = 1'b1;
    ticks(4);
    check("req_held", {15'd0, int_req}, 16'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("ack_sets_i", {8'h00, flags_in}, 16'h0035);
    check("ack_drop",   {15'd0, int_req}, 16'd0);
    pulse_done();
    irq_n = 1'b0;

    // Stray ack ignored; NMI priority over IRQ
    set_i(1'b0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("stray_ack", {8'h00, flags_in}, 16'h0031);
    pulse_done();
    nmi_n = 1'b0;
    ticks(4);
    pulse_done();
    check("nmi_prio_req", {15'd0, int_req}, 16'd1);
    check("nmi_prio_sel", {15'd0, int_is_nmi}, 16'd1);
    check("nmi_vec",      int_vector, 16'hFFFA);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    pulse_done();
    pulse_done();
    pulse_done();
    check("irq_masked_after", {15'd0, int_req}, 16'd0);
    nmi_n = 1'b1;
    ticks(4);

    // NMI edge coinciding with NMI acknowledge
    nmi_n = 1'b0;
    ticks(4);
    pulse_done();
    check("nmi2_req", {15'd0, int_req}, 16'd1);
    nmi_n = 1'b1;
    ticks(4);
    nmi_n = 1'b0;
    ticks(S);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("edge_ack_drop", {15'd0, int_req}, 16'd0);
    pulse_done();
    check("svc_end_noreq", {15'd0, int_req}, 16'd0);
    tick();
    pulse_done();
    check("relatched_req", {15'd0, int_req}, 16'd1);
    check("relatched_nmi", {15'd0, int_is_nmi}, 16'd1);

    // Reset while a request is pending
    nmi_n = 1'b1;
    rst_n = 1'b0;
    #2 check_reset_lits();
    ticks(2);
    rst_n = 1'b1;
    ticks(4);
    pulse_done();
    check("nmi_lost", {15'd0, int_req}, 16'd0);
    irq_n = 1'b1;
    ticks(4);

`ifdef STATUS_WAI_EN
    wai_req = 1'b1; tick(); wai_req = 1'b0;
    check("wai_enter", {15'd0, wai_halt}, 16'd1);
    irq_n = 1'b0;
    tick();
    check("wai_hold", {15'd0, wai_halt}, 16'd1);
    ticks(S);
    check("wai_exit_masked", {15'd0, wai_halt}, 16'd0);
    check("wai_no_req",      {15'd0, int_req}, 16'd0);
    irq_n = 1'b1;
    ticks(4);
    set_i(1'b0);
    pulse_done();
    wai_req = 1'b1; tick(); wai_req = 1'b0;
    irq_n = 1'b0;
    ticks(S + 1);
    check("wai_exit_open", {15'd0, wai_halt}, 16'd0);
    check("wai_req_irq",   {15'd0, int_req}, 16'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    pulse_done();
    irq_n = 1'b1;
    ticks(4);
`else
    wai_req = 1'b1; tick(); wai_req = 1'b0;
    check("wai_ignored", {15'd0, wai_halt}, 16'd0);
    ticks(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/status_interrupt_unit.md
Name: status_interrupt_unit

Overview:
- Holds the processor status register P (N V 1 B D I Z C) and commits the arithmetic unit's `flags_out`/`flags_ena` into P each cycle.
- Feeds P back to the arithmetic unit as `flags_in`.
- Synchronises `irq_n`/`nmi_n` and detects NMI edges.
- Raises interrupt requests to the instruction sequencer at instruction boundaries using a req/ack handshake, with a 6502-style delayed I-mask.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on `irq_n` and `nmi_n` (≥2).
- RESET_P, 8'h34, P value after reset (I=1, D=0).
- NMI_VECTOR, 16'hFFFA, vector address for NMI.
- IRQ_VECTOR, 16'hFFFE, vector address for IRQ.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flags_out  in  8  flag values from the arithmetic unit
- flags_ena  in  8  per-bit write enables from the arithmetic unit
- flags_wr  in  1  commit `flags_out`/`flags_ena` this cycle
- p_load  in  1  PLP: load P from `p_load_data`
- p_load_data  in  8  byte pulled from the stack
- push_b  in  1  B value for `p_push` (1 = BRK/PHP, 0 = hardware interrupt)
- instr_done  in  1  one-cycle pulse at the last cycle of each instruction
- int_ack  in  1  sequencer accepts the pending interrupt
- irq_n  in  1  asynchronous IRQ, active low, level
- nmi_n  in  1  asynchronous NMI, active low, falling edge
- wai_req  in  1  WAI executed (used only with the optional feature)
- flags_in  out  8  current P to the arithmetic unit; bits 5 and 4 read 1
- p_push  out  8  {N,V,1,push_b,D,I,Z,C} for stack push
- int_req  out  1  interrupt pending to the sequencer
- int_is_nmi  out  1  pending/serviced interrupt is NMI
- int_vector  out  16  NMI_VECTOR or IRQ_VECTOR per `int_is_nmi`
- wai_halt  out  1  sequencer must stall (optional feature)

Behaviour:
- Reset (async, rst_n=0) values:
  - stored P = RESET_P, so `flags_in` = 8'h34
  - all synchronisers = 1; `nmi_latch` = 0; `i_eff` = 1
  - FSM = IDLE; `int_req`, `int_is_nmi`, `wai_halt` = 0
  - `int_vector` = IRQ_VECTOR
- Stored bits are 7, 6, 3, 2, 1, 0. Bits 5 and 4 are not stored and read 1 on `flags_in`.
- P update per cycle, in priority order, lowest to highest:
  1. `flags_wr`: bit i <= `flags_out[i]` where `flags_ena[i]`.
  2. `p_load` overrides step 1 for all stored bits.
  3. `int_ack` in REQ forces I=1, overriding steps 1 and 2.
- P updates are registered; `flags_in` reflects them the next cycle.
- Synchronisers: `irq_s`/`nmi_s` are outputs of SYNC_STAGES flip-flops, reset to 1.
- NMI latch: a 1→0 transition on `nmi_s` sets `nmi_latch`. It clears on `int_ack` when `int_is_nmi`=1. A new edge in the same cycle as the clear wins, so the latch stays set.
- Delayed mask: `i_eff` <= P.I (pre-update value) on each `instr_done`. CLI/SEI therefore affect IRQ gating one instruction late.
- `irq_pend` = ~`irq_s` & ~`i_eff`.
- FSM:
  - IDLE: on `instr_done` with (`nmi_latch` | `irq_pend`) → REQ. Set `int_req`=1 and `int_is_nmi`=`nmi_latch` (NMI has priority). The selection is frozen until ack.
  - REQ: `int_req` held high until `int_ack`. IRQ deasserting in REQ does not withdraw the request. On `int_ack` → SVC; `int_req` drops the same edge.
  - SVC: no new requests. → IDLE on `instr_done` (end of the vector sequence).
- `int_ack` outside REQ is ignored.
- `int_vector` is combinational from `int_is_nmi`, valid in REQ and SVC.
- Reset mid-REQ/SVC returns immediately to the reset state; the pending NMI is lost.

Optional Feature:
- Macro: STATUS_WAI_EN.
- Defined:
  - `wai_req` in IDLE → state WAIT with `wai_halt`=1 from the next cycle.
  - WAIT exits when `nmi_latch` | ~`irq_s`, regardless of I.
  - Exit to REQ if `nmi_latch` | `irq_pend`; otherwise to IDLE (resume without vectoring, 65C02 semantics).
  - `wai_halt` drops on the exit edge.
- Undefined: `wai_req` ignored; `wai_halt` tied 0; no WAIT state.

Test Plan:
- Reset → `flags_in`=8'h34; after release, `flags_wr`=1, `flags_out`=8'hC3, `flags_ena`=8'hC3 → `flags_in`=8'hF7 next cycle.
- Same cycle `flags_wr` (`flags_ena`=8'h01, C=0) and `p_load` with `p_load_data`=8'h01 → C=1 (PLP wins); `p_push` with `push_b`=0 shows bit4=0, bit5=1.
- `irq_n`=0 with P.I=1, then CLI (I cleared) at `instr_done` #1 → `int_req` only after `instr_done` #2; `int_ack` → I=1, `int_vector`=16'hFFFE, return to IDLE at the next `instr_done`.
- IRQ and NMI edge both pending at `instr_done` → `int_is_nmi`=1, `int_vector`=16'hFFFA; after ack and SVC completion, IRQ still low with I=1 → no request.
- NMI edge arrives in the same cycle as NMI `int_ack` → `nmi_latch` stays 1; a second request is raised at the first `instr_done` after SVC ends.
- With STATUS_WAI_EN: `wai_req`, then `irq_n`=0 with I=1 → `wai_halt` 1 then 0, FSM to IDLE, `int_req` stays 0. Repeat with I=0 → `int_req`=1.
